// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, single-outstanding imem request,
// one-entry skid buffer, discard state for in-flight flushes, and IF/ID reg.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   PC_Stall, IF_ID_Stall      hazard-unit freeze (treated identically)
//   Branch_Taken/Target        EX-stage redirect; wins over stall
//   imem_req/addr              fetch request, address held until imem_ready
//   imem_ready/rdata           response strobe and instruction word
//   IF_ID_pc/instr/valid       pipeline register toward decode
//   perf_fetched/stall_cyc/flushes   only with FETCH_PERF_EN defined
//
// Optional feature macro: FETCH_PERF_EN (adds 32-bit event counters).

module fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PC_Stall,
    input  logic            IF_ID_Stall,
    input  logic            Branch_Taken,
    input  logic [XLEN-1:0] Branch_Target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_flushes
`endif
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    // Registered state
    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_tgt;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            skid_valid;
    logic            active;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;

    // Next-state values
    logic [1:0]      state_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] pend_tgt_n;
    logic [XLEN-1:0] skid_pc_n;
    logic [31:0]     skid_instr_n;
    logic            skid_valid_n;
    logic [XLEN-1:0] ifid_pc_n;
    logic [31:0]     ifid_instr_n;
    logic            ifid_valid_n;
    logic            load_real;

    logic            stall;
    logic            rsp;
    logic [XLEN-1:0] pc_inc;

    assign stall  = PC_Stall | IF_ID_Stall;
    assign pc_inc = pc + XLEN'(4);

    // The request stays low until the first edge after reset so that a
    // response can never be accepted for a request that was not issued.
    assign imem_req  = active & (state != HOLD);
    assign imem_addr = pc;
    assign rsp       = imem_req & imem_ready;

    assign IF_ID_pc    = ifid_pc;
    assign IF_ID_instr = ifid_instr;
    assign IF_ID_valid = ifid_valid;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_tgt_n   = pend_tgt;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        skid_valid_n = skid_valid;
        ifid_pc_n    = ifid_pc;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;
        load_real    = 1'b0;

        unique case (state)
            FETCH: begin
                if (Branch_Taken) begin
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    // With no request in flight the redirect is immediate;
                    // otherwise the pending response must be drained first.
                    if (rsp || !active) begin
                        pc_n = Branch_Target;
                    end else begin
                        pend_tgt_n = Branch_Target;
                        state_n    = DISCARD;
                    end
                end else if (stall) begin
                    if (rsp) begin
                        skid_pc_n    = pc;
                        skid_instr_n = imem_rdata;
                        skid_valid_n = 1'b1;
                        pc_n         = pc_inc;
                        state_n      = HOLD;
                    end
                end else if (rsp) begin
                    ifid_pc_n    = pc;
                    ifid_instr_n = imem_rdata;
                    ifid_valid_n = 1'b1;
                    load_real    = 1'b1;
                    pc_n         = pc_inc;
                end else begin
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                end
            end

            HOLD: begin
                if (Branch_Taken) begin
                    skid_valid_n = 1'b0;
                    pc_n         = Branch_Target;
                    ifid_instr_n = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    state_n      = FETCH;
                end else if (!stall) begin
                    ifid_pc_n    = skid_pc;
                    ifid_instr_n = skid_instr;
                    ifid_valid_n = 1'b1;
                    load_real    = 1'b1;
                    skid_valid_n = 1'b0;
                    state_n      = FETCH;
                end
            end

            DISCARD: begin
                ifid_instr_n = NOP_INSTR;
                ifid_valid_n = 1'b0;
                if (Branch_Taken) begin
                    pend_tgt_n = Branch_Target;
                end
                // A redirect arriving with the response overrides pend_tgt.
                if (rsp) begin
                    pc_n    = Branch_Taken ? Branch_Target : pend_tgt;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend_tgt   <= RESET_PC;
            skid_pc    <= RESET_PC;
            skid_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            active     <= 1'b0;
            ifid_pc    <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_tgt   <= pend_tgt_n;
            skid_pc    <= skid_pc_n;
            skid_instr <= skid_instr_n;
            skid_valid <= skid_valid_n;
            active     <= 1'b1;
            ifid_pc    <= ifid_pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] cnt_fetched;
    logic [31:0] cnt_stall;
    logic [31:0] cnt_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_fetched <= '0;
            cnt_stall   <= '0;
            cnt_flush   <= '0;
        end else begin
            if (load_real) begin
                cnt_fetched <= cnt_fetched + 32'd1;
            end
            if (stall) begin
                cnt_stall <= cnt_stall + 32'd1;
            end
            if (Branch_Taken) begin
                cnt_flush <= cnt_flush + 32'd1;
            end
        end
    end

    assign perf_fetched   = cnt_fetched;
    assign perf_stall_cyc = cnt_stall;
    assign perf_flushes   = cnt_flush;
`else
    logic unused_load_real;
    assign unused_load_real = load_real;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus for fetch_stage with immediate assertions.
// Instruction memory returns 0xC000_0000 | (addr >> 2) combinationally.

module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        PC_Stall;
    logic        IF_ID_Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flushes;
`endif

    int n_checks;
    int n_pass;
    int n_fail;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .PC_Stall      (PC_Stall),
        .IF_ID_Stall   (IF_ID_Stall),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flushes  (perf_flushes)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC000_0000 | (a >> 2);
    endfunction

    assign imem_rdata = mem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] p,
                            input logic [31:0] ins, input logic v);
        chk({tag, "_pc"}, IF_ID_pc, p);
        chk({tag, "_instr"}, IF_ID_instr, ins);
        chk({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
    endtask

    task automatic chk_req(input string tag, input logic r,
                           input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) chk({tag, "_addr"}, imem_addr, a);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        n_fail = 0;
        reset = 1'b1;
        PC_Stall = 1'b0;
        IF_ID_Stall = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Target = '0;
        imem_ready = 1'b0;

        // Reset values
        #2;
        chk_ifid("rst", 32'h0, NOP, 1'b0);
        chk_req("rst", 1'b0, 32'h0);
        step();
        step();
        chk_req("rst_hold", 1'b0, 32'h0);

        // Sequential fetch
        reset = 1'b0;
        imem_ready = 1'b1;
        step();
        chk_req("first_req", 1'b1, 32'h0);
        chk("first_bubble", {31'd0, IF_ID_valid}, 32'd0);
        step();
        chk_ifid("seq0", 32'h0, 32'hC000_0000, 1'b1);
        chk_req("seq0", 1'b1, 32'h4);
        step();
        chk_ifid("seq4", 32'h4, 32'hC000_0001, 1'b1);
        chk_req("seq4", 1'b1, 32'h8);

        // Stall two cycles with response at 0x8 -> skid, HOLD
        PC_Stall = 1'b1;
        step();
        chk_ifid("stall1", 32'h4, 32'hC000_0001, 1'b1);
        chk_req("stall1", 1'b0, 32'h0);
        PC_Stall = 1'b0;
        IF_ID_Stall = 1'b1;
        step();
        chk_ifid("stall2", 32'h4, 32'hC000_0001, 1'b1);
        chk_req("stall2", 1'b0, 32'h0);
        IF_ID_Stall = 1'b0;
        step();
        chk_ifid("skid_out", 32'h8, 32'hC000_0002, 1'b1);
        chk_req("skid_out", 1'b1, 32'hC);
        step();
        chk_ifid("after_skid", 32'hC, 32'hC000_0003, 1'b1);
        chk_req("after_skid", 1'b1, 32'h10);

        // Redirect with response in the same cycle
        Branch_Taken = 1'b1;
        Branch_Target = 32'h40;
        step();
        chk_ifid("br_bubble", 32'hC, NOP, 1'b0);
        chk_req("br_bubble", 1'b1, 32'h40);
        Branch_Taken = 1'b0;
        step();
        chk_ifid("br_tgt", 32'h40, 32'hC000_0010, 1'b1);
        chk_req("br_tgt", 1'b1, 32'h44);

        // Steer back to 0x10, then slow memory + flush -> DISCARD
        Branch_Taken = 1'b1;
        Branch_Target = 32'h10;
        step();
        chk_req("to10", 1'b1, 32'h10);
        Branch_Taken = 1'b0;
        imem_ready = 1'b0;
        step();
        chk_ifid("wait0", 32'h40, NOP, 1'b0);
        chk_req("wait0", 1'b1, 32'h10);
        Branch_Taken = 1'b1;
        Branch_Target = 32'h80;
        step();
        chk_ifid("disc1", 32'h40, NOP, 1'b0);
        chk_req("disc1", 1'b1, 32'h10);
        Branch_Taken = 1'b0;
        step();
        chk_ifid("disc2", 32'h40, NOP, 1'b0);
        chk_req("disc2", 1'b1, 32'h10);
        imem_ready = 1'b1;
        step();
        chk_ifid("disc_drop", 32'h40, NOP, 1'b0);
        chk_req("disc_drop", 1'b1, 32'h80);
        step();
        chk_ifid("disc_tgt", 32'h80, 32'hC000_0020, 1'b1);
        chk_req("disc_tgt", 1'b1, 32'h84);

        // Redirect and stall together: redirect wins
        Branch_Taken = 1'b1;
        Branch_Target = 32'h100;
        IF_ID_Stall = 1'b1;
        step();
        chk_ifid("br_stall", 32'h80, NOP, 1'b0);
        chk_req("br_stall", 1'b1, 32'h100);
        Branch_Taken = 1'b0;
        IF_ID_Stall = 1'b0;
        step();
        chk_ifid("br_stall_tgt", 32'h100, 32'hC000_0040, 1'b1);

        // PC wrap at top of address space
        Branch_Taken = 1'b1;
        Branch_Target = 32'hFFFF_FFFC;
        step();
        chk_req("wrap_tgt", 1'b1, 32'hFFFF_FFFC);
        Branch_Taken = 1'b0;
        step();
        chk_ifid("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1);
        chk_req("wrap_top", 1'b1, 32'h0);

        // Stall without response: everything holds
        imem_ready = 1'b0;
        PC_Stall = 1'b1;
        step();
        chk_ifid("stall_nr", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1);
        chk_req("stall_nr", 1'b1, 32'h0);
        PC_Stall = 1'b0;
        imem_ready = 1'b1;
        step();
        chk_ifid("wrap0", 32'h0, 32'hC000_0000, 1'b1);
        chk_req("wrap0", 1'b1, 32'h4);

        // Async reset in DISCARD
        imem_ready = 1'b0;
        Branch_Taken = 1'b1;
        Branch_Target = 32'h200;
        step();
        Branch_Taken = 1'b0;
        chk_req("pre_rst_disc", 1'b1, 32'h4);
        #2;
        reset = 1'b1;
        #1;
        chk_ifid("async_rst", 32'h0, NOP, 1'b0);
        chk_req("async_rst", 1'b0, 32'h0);
        chk("async_rst_addr", imem_addr, 32'h0);
        step();
        reset = 1'b0;
        imem_ready = 1'b1;
        step();
        chk_req("rst_refetch", 1'b1, 32'h0);
        step();
        chk_ifid("rst_first", 32'h0, 32'hC000_0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
